muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit; sits directly downstream of the register file.
- Consumes the two register read operands and produces a write-back result, destination register index and one-cycle write strobe.
- These outputs drive the register file write port (wd / a3 / we).
- Multi-cycle; the core stalls on busy.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only when busy=0
funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value (rd1)
op_b  in  XLEN  rs2 value (rd2)
rd_in  in  REG_AW  destination register index
flush  in  1  abort in-flight operation
busy  out  1  operation in flight (state != IDLE)
done  out  1  one-cycle result strobe; drives regfile we
result  out  XLEN  write-back data; drives regfile wd
rd_out  out  REG_AW  captured rd_in; drives regfile a3

Behaviour:
- Reset (asynchronous, any time, including mid-operation): state=IDLE; busy, done, result, rd_out and all internal registers = 0.
- States: IDLE, CALC, DONE.
- IDLE + start at edge E: latch funct3, rd_in and |op_a| / |op_b| per signedness. Latch result-sign flags. Load the iteration counter with XLEN-1.
  - Normal case: go to CALC.
  - Special cases: go to DONE.
- CALC: one shift-add (multiply) or one restoring-subtract (divide) step per cycle. Counter decrements each step. When the counter reaches 0, go to DONE.
- DONE: done=1 for exactly one cycle with the final result and rd_out, then IDLE.
- Latency: done is high in the cycle following edge E+XLEN+1 (33 edges for XLEN=32); special cases after edge E+1.
- busy: high from edge E through the DONE cycle inclusive.
- result and rd_out hold their value after done until the next done.
- Sign rules:
  - MUL/MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - MUL returns the low XLEN bits of the 2*XLEN-bit product; MULH* return the high XLEN bits.
  - The product is negated when the operand signs differ.
  - Quotient is negated when the operand signs differ; remainder takes the dividend's sign.
  - All arithmetic is modulo 2^XLEN.
- Special cases (no iteration):
  - Divide by zero: DIV/DIVU return all-ones; REM/REMU return op_a.
  - Signed overflow (op_a = most-negative, op_b = -1): DIV returns op_a; REM returns 0.
- start while busy=1: ignored; no queueing.
- flush: synchronous; takes priority over everything except reset.
  - State goes to IDLE and busy drops at the next edge.
  - No done for the aborted op; result and rd_out are unchanged.
  - start in the same cycle as flush is ignored.
- rd_in = 0: operation executes normally. rd_out = 0 is forwarded; discarding the write is the register file's concern.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined: the four multiply ops use a combinational 2*XLEN-bit product and go IDLE to DONE (latency: done in the cycle after edge E+1). Divide ops are unchanged.
- Undefined: all ops are iterative as above; no XLEN x XLEN multiplier is inferred.

Decomposition:
- Shared package riscv_pkg:
  - funct3 constants (F3_MUL … F3_REMU)
  - state encoding (ST_IDLE, ST_CALC, ST_DONE)
  - XLEN / REG_AW defaults
- No sub-module required.
- Sign pre-conditioning and post-negation live in the unit itself; the datapath is a single shared accumulator/remainder register pair.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 -> done exactly 33 edges after start, result=0xFFFFFFEB, rd_out=5; busy high throughout; done a single-cycle pulse.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV x/0 -> 0xFFFFFFFF. REMU 0x1234/0 -> 0x1234. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same -> 0. All special cases: done one cycle after the start edge.
- Start DIVU, pulse start with new operands at cycle 10 -> ignored, original result delivered. Flush at cycle 12 -> no done, busy low next cycle, result unchanged. New op then completes normally.
- Assert reset at cycle 20 of a MUL -> busy, done, result, rd_out = 0 immediately (asynchronous). After release, MUL 3x4 -> 12. With MULDIV_FAST_MUL_EN defined: 12 at latency 1.

Source files
------------

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32M definitions for the multiply/divide unit:
//                funct3 opcodes, FSM state encoding, default widths and a
//                small opcode-classification helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Default widths
    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // All divide/remainder opcodes have funct3[2] set
    function automatic logic f3_is_div(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Request/response bundle between the issue logic / register
//                file and the multiply/divide unit. The master issues the
//                operation; the slave (the unit) returns the write-back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              start;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [REG_AW-1:0] rd_in;
    logic              flush;
    logic              busy;
    logic              done;
    logic [XLEN-1:0]   result;
    logic [REG_AW-1:0] rd_out;

    modport master (
        output start, funct3, op_a, op_b, rd_in, flush,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd_in, flush,
        output busy, done, result, rd_out
    );

endinterface : muldiv_unit_if
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_unit
//  Description : Iterative RV32M multiply/divide unit. Operands are reduced
//                to magnitudes on issue, a single accumulator/low register
//                pair runs a shift-add multiply or restoring divide (one bit
//                per cycle), and the sign is restored on the last CALC cycle.
//                Optional build macro: MULDIV_FAST_MUL_EN - multiplies use a
//                single-cycle combinational product instead of iterating.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import riscv_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);

    // Counter runs XLEN-1 .. 0 for the XLEN datapath steps, then wraps to
    // all-ones; the sign bit being set marks the sign-restore cycle.
    localparam int              CW       = $clog2(XLEN) + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        f3_q;
    logic [REG_AW-1:0] rd_q, rd_out_q;
    logic              neg_q;      // negate product / quotient
    logic              rneg_q;     // negate remainder
    logic [XLEN-1:0]   acc_q;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q;       // multiplier -> product low / dividend -> quotient
    logic [XLEN-1:0]   dvs_q;      // multiplicand or divisor magnitude
    logic [XLEN-1:0]   result_q;
    logic [CW-1:0]     cnt_q;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_abs, b_abs;
    logic              is_div, b_zero, div_ovf, special;
    logic [XLEN-1:0]   spec_quo, spec_rem;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   acc_step, lo_step;

    logic [2*XLEN-1:0] prod_mag, prod_fin;
    logic [XLEN-1:0]   quo_fin, rem_fin, fin_res;

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`endif

    // Operand sign conditioning and divide special-case detection on issue
    always_comb begin
        a_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                   (bus.funct3 == F3_MULHSU) || (bus.funct3 == F3_DIV) ||
                   (bus.funct3 == F3_REM);
        b_signed = (bus.funct3 == F3_MUL) || (bus.funct3 == F3_MULH) ||
                   (bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM);
        a_neg    = a_signed & bus.op_a[XLEN-1];
        b_neg    = b_signed & bus.op_b[XLEN-1];
        a_abs    = a_neg ? (-bus.op_a) : bus.op_a;
        b_abs    = b_neg ? (-bus.op_b) : bus.op_b;
        is_div   = f3_is_div(bus.funct3);
        b_zero   = (bus.op_b == '0);
        div_ovf  = ((bus.funct3 == F3_DIV) || (bus.funct3 == F3_REM)) &&
                   (bus.op_a == MOST_NEG) && (bus.op_b == '1);
        special  = is_div & (b_zero | div_ovf);
        spec_quo = b_zero ? '1 : bus.op_a;
        spec_rem = b_zero ? bus.op_a : '0;
    end

    // One shift-add or restoring-subtract step of the shared datapath
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
        div_shift = {acc_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, dvs_q};
        div_ge    = ~div_diff[XLEN];
        if (f3_q[2]) begin
            acc_step = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_step  = {lo_q[XLEN-2:0], div_ge};
        end else begin
            acc_step = mul_sum[XLEN:1];
            lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign restoration and result selection for the final cycle
    always_comb begin
        prod_mag = {acc_q, lo_q};
        prod_fin = neg_q  ? (-prod_mag) : prod_mag;
        quo_fin  = neg_q  ? (-lo_q)     : lo_q;
        rem_fin  = rneg_q ? (-acc_q)    : acc_q;
        case (f3_q)
            F3_MUL:                        fin_res = prod_fin[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  fin_res = prod_fin[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               fin_res = quo_fin;
            default:                       fin_res = rem_fin;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state; special cases and fast multiplies enter CALC with the
    // counter already expired so only the sign-restore cycle is spent there
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_CALC;
            ST_CALC: if (cnt_q[CW-1]) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs
    always_comb begin
        bus.busy = (state_q != ST_IDLE);
        bus.done = (state_q == ST_DONE);
    end

    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;

    // Datapath: operand capture on issue, iteration, result write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f3_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            lo_q     <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
        end else if (!bus.flush) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        f3_q <= bus.funct3;
                        rd_q <= bus.rd_in;
                        if (special) begin
                            acc_q  <= spec_rem;
                            lo_q   <= spec_quo;
                            dvs_q  <= '0;
                            neg_q  <= 1'b0;
                            rneg_q <= 1'b0;
                            cnt_q  <= '1;
                        end else if (is_div) begin
                            acc_q  <= '0;
                            lo_q   <= a_abs;
                            dvs_q  <= b_abs;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= a_neg;
                            cnt_q  <= CNT_LOAD;
`ifdef MULDIV_FAST_MUL_EN
                        end else begin
                            acc_q  <= fast_prod[2*XLEN-1:XLEN];
                            lo_q   <= fast_prod[XLEN-1:0];
                            dvs_q  <= '0;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= 1'b0;
                            cnt_q  <= '1;
                        end
`else
                        end else begin
                            acc_q  <= '0;
                            lo_q   <= b_abs;
                            dvs_q  <= a_abs;
                            neg_q  <= a_neg ^ b_neg;
                            rneg_q <= 1'b0;
                            cnt_q  <= CNT_LOAD;
                        end
`endif
                    end
                end
                ST_CALC: begin
                    if (cnt_q[CW-1]) begin
                        result_q <= fin_res;
                        rd_out_q <= rd_q;
                    end else begin
                        acc_q <= acc_step;
                        lo_q  <= lo_step;
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_unit
//  Description : Directed, table-driven bench for muldiv_unit plus hand-
//                written sequences for ignored start, flush and async reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import riscv_pkg::*;

    localparam int LN = 33;   // iterative latency (edges from start to done)
    localparam int LS = 1;    // divide special-case latency
`ifdef MULDIV_FAST_MUL_EN
    localparam int LM = 1;
`else
    localparam int LM = 33;
`endif
    localparam int NV = 20;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    muldiv_unit_if #(.XLEN(32), .REG_AW(5)) bus ();

    muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to its done pulse; optionally pulse
    // a foreign start request while the unit is busy.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int poke_at,
                         output logic [31:0] res, output logic [4:0] rdo,
                         output int lat, output bit busy_ok, output bit pulse_ok);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op_a   = a;
        bus.op_b   = b;
        bus.rd_in  = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat       = 0;
        busy_ok   = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            if (lat == poke_at) begin
                bus.start  = 1'b1;
                bus.funct3 = F3_MUL;
                bus.op_a   = 32'hDEAD_BEEF;
                bus.op_b   = 32'h0000_0005;
                bus.rd_in  = 5'd30;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        res = bus.result;
        rdo = bus.rd_out;
        @(posedge clk); #1;
        pulse_ok = (bus.done === 1'b0) && (bus.busy === 1'b0);
    endtask

    task automatic run_and_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd, input int poke_at,
                                 input logic [31:0] exp, input int exp_lat);
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        bit          busy_ok, pulse_ok;
        do_op(f3, a, b, rd, poke_at, res, rdo, lat, busy_ok, pulse_ok);
        check({tag, " result"}, res, exp);
        check({tag, " rd_out"}, {27'd0, rdo}, {27'd0, rd});
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy held"}, {31'd0, busy_ok}, 32'd1);
        check({tag, " done pulse"}, {31'd0, pulse_ok}, 32'd1);
    endtask

    vec_t vecs[NV];

    initial begin
        n_pass      = 0;
        n_total     = 0;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.funct3  = 3'd0;
        bus.op_a    = 32'd0;
        bus.op_b    = 32'd0;
        bus.rd_in   = 5'd0;

        vecs[0]  = '{F3_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, LM};
        vecs[1]  = '{F3_MULH,   32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, LM};
        vecs[2]  = '{F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, LM};
        vecs[3]  = '{F3_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8,  32'hFFFF_FFFF, LM};
        vecs[4]  = '{F3_MULH,   32'hFFFF_FFFF, 32'h7FFF_FFFF, 5'd9,  32'hFFFF_FFFF, LM};
        vecs[5]  = '{F3_MUL,    32'h1234_5678, 32'h0000_0010, 5'd10, 32'h2345_6780, LM};
        vecs[6]  = '{F3_MUL,    32'h0000_0003, 32'h0000_0004, 5'd0,  32'h0000_000C, LM};
        vecs[7]  = '{F3_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFD, LN};
        vecs[8]  = '{F3_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd12, 32'hFFFF_FFFF, LN};
        vecs[9]  = '{F3_DIVU,   32'd100,       32'd7,         5'd13, 32'd14,        LN};
        vecs[10] = '{F3_REMU,   32'd100,       32'd7,         5'd14, 32'd2,         LN};
        vecs[11] = '{F3_DIV,    32'h0000_0007, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFD, LN};
        vecs[12] = '{F3_REM,    32'h0000_0007, 32'hFFFF_FFFE, 5'd16, 32'h0000_0001, LN};
        vecs[13] = '{F3_DIVU,   32'hFFFF_FFFF, 32'h0000_0001, 5'd17, 32'hFFFF_FFFF, LN};
        vecs[14] = '{F3_DIV,    32'h0000_0055, 32'h0000_0000, 5'd18, 32'hFFFF_FFFF, LS};
        vecs[15] = '{F3_DIVU,   32'h0000_0005, 32'h0000_0000, 5'd19, 32'hFFFF_FFFF, LS};
        vecs[16] = '{F3_REMU,   32'h0000_1234, 32'h0000_0000, 5'd20, 32'h0000_1234, LS};
        vecs[17] = '{F3_REM,    32'h0000_0037, 32'h0000_0000, 5'd21, 32'h0000_0037, LS};
        vecs[18] = '{F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'h8000_0000, LS};
        vecs[19] = '{F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd23, 32'h0000_0000, LS};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset busy",   {31'd0, bus.busy}, 32'd0);
        check("reset done",   {31'd0, bus.done}, 32'd0);
        check("reset result", bus.result,        32'd0);
        check("reset rd_out", {27'd0, bus.rd_out}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table
        for (int i = 0; i < NV; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                          vecs[i].rd, -1, vecs[i].exp, vecs[i].lat);
        end

        // Start while busy is ignored: 1000/7 = 142
        run_and_check("ignored start", F3_DIVU, 32'd1000, 32'd7, 5'd9, 9, 32'd142, LN);

        // Flush mid-divide: no done, busy drops, result/rd_out retained
        bus.start  = 1'b1;
        bus.funct3 = F3_DIVU;
        bus.op_a   = 32'd5000;
        bus.op_b   = 32'd3;
        bus.rd_in  = 5'd11;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush busy",   {31'd0, bus.busy}, 32'd0);
        check("flush result", bus.result, 32'd142);
        check("flush rd_out", {27'd0, bus.rd_out}, 32'd9);
        begin
            bit saw_done;
            saw_done = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (bus.done === 1'b1) saw_done = 1'b1;
                @(posedge clk); #1;
            end
            check("flush no done", {31'd0, saw_done}, 32'd0);
        end

        // Start together with flush is dropped
        bus.start  = 1'b1;
        bus.flush  = 1'b1;
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'd9;
        bus.op_b   = 32'd9;
        bus.rd_in  = 5'd4;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("start+flush busy", {31'd0, bus.busy}, 32'd0);

        // Normal operation after flush: 1000 % 7 = 6
        run_and_check("post-flush", F3_REMU, 32'd1000, 32'd7, 5'd12, -1, 32'd6, LN);

        // Asynchronous reset in the middle of a multiply
        bus.start  = 1'b1;
        bus.funct3 = F3_MUL;
        bus.op_a   = 32'h0000_1234;
        bus.op_b   = 32'h0000_5678;
        bus.rd_in  = 5'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async rst busy",   {31'd0, bus.busy}, 32'd0);
        check("async rst done",   {31'd0, bus.done}, 32'd0);
        check("async rst result", bus.result,        32'd0);
        check("async rst rd_out", {27'd0, bus.rd_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        run_and_check("post-reset", F3_MUL, 32'd3, 32'd4, 5'd1, -1, 32'd12, LM);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_muldiv_unit
`default_nettype wire
